// File: rtl/sr_frame_feeder.sv
// Serialiser feeding fixed-length shift-register chains.
// Words stream LSB-first per lane; frame end appends depth zero bits.
module sr_frame_feeder #(
    parameter int width  = 1,
    parameter int word_w = 8,
    parameter int depth  = 130
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [width*word_w-1:0]   s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [width-1:0]          sh_d,
    output logic                      sh_e,
    output logic                      busy,
    output logic                      flush_done
);
    localparam int BW = (word_w > 1) ? $clog2(word_w) : 1;
    localparam int FW = $clog2(depth + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FLUSH
    } state_t;

    state_t                    state;
    logic [BW-1:0]             bit_idx;
    logic [FW-1:0]             flush_cnt;
    logic                      last_q;
    logic [width*word_w-1:0]   shreg;
    logic                      last_bit;
    logic                      accept;

    function automatic logic [width-1:0] lane_lsb(
        input logic [width*word_w-1:0] v
    );
        logic [width-1:0] r;
        for (int w = 0; w < width; w++)
            r[w] = v[w*word_w];
        return r;
    endfunction

    function automatic logic [width*word_w-1:0] lane_shr(
        input logic [width*word_w-1:0] v
    );
        logic [width*word_w-1:0] r;
        for (int w = 0; w < width; w++)
            r[w*word_w +: word_w] = v[w*word_w +: word_w] >> 1;
        return r;
    endfunction

    assign last_bit = (bit_idx == BW'(word_w - 1));
    assign busy     = (state != IDLE);
    assign accept   = s_valid && s_ready;

    // Ready depends on registered state only, so upstream sees no comb loop.
    assign s_ready = rst_n &&
                     ((state == IDLE) ||
                      (state == SHIFT && last_bit && !last_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_idx    <= '0;
            flush_cnt  <= '0;
            last_q     <= 1'b0;
            shreg      <= '0;
            sh_d       <= '0;
            sh_e       <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh_d    <= lane_lsb(s_data);
                        shreg   <= lane_shr(s_data);
                        sh_e    <= 1'b1;
                        bit_idx <= '0;
                        last_q  <= s_last;
                        state   <= SHIFT;
                    end else begin
                        sh_d <= '0;
                        sh_e <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        sh_d    <= lane_lsb(shreg);
                        shreg   <= lane_shr(shreg);
                        bit_idx <= bit_idx + BW'(1);
                    end else if (last_q) begin
                        state     <= FLUSH;
                        sh_d      <= '0;
                        sh_e      <= 1'b1;
                        flush_cnt <= '0;
                        last_q    <= 1'b0;
                    end else if (accept) begin
                        // back-to-back word: no bubble on sh_e
                        sh_d    <= lane_lsb(s_data);
                        shreg   <= lane_shr(s_data);
                        bit_idx <= '0;
                        last_q  <= s_last;
                    end else begin
                        state <= IDLE;
                        sh_d  <= '0;
                        sh_e  <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FW'(depth - 1)) begin
                        state      <= IDLE;
                        sh_e       <= 1'b0;
                        flush_done <= 1'b1;
                        flush_cnt  <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    sh_d  <= '0;
                    sh_e  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sr_frame_feeder.sv
// Bench for sr_frame_feeder: two instances checked every cycle
// against a queue-of-symbols reference model.
module tb_sr_frame_feeder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] dat[2];
    logic [1:0]  vld, lst;
    logic [1:0]  rdy, e, fd, bsy;
    logic [1:0]  d0;
    logic        d1;

    int tests = 0;
    int fails = 0;

    // A: two lanes of 8 bits, short flush
    sr_frame_feeder #(.width(2), .word_w(8), .depth(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_data(dat[0]),
        .s_valid(vld[0]), .s_last(lst[0]), .s_ready(rdy[0]),
        .sh_d(d0), .sh_e(e[0]), .busy(bsy[0]), .flush_done(fd[0])
    );

    // B: single lane, 1-bit words, long flush
    sr_frame_feeder #(.width(1), .word_w(1), .depth(130)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data(dat[1][0:0]),
        .s_valid(vld[1]), .s_last(lst[1]), .s_ready(rdy[1]),
        .sh_d(d1), .sh_e(e[1]), .busy(bsy[1]), .flush_done(fd[1])
    );

    typedef struct packed {
        logic [1:0] d;
        logic       fin;
    } sym_t;

    sym_t       q[2][$];
    logic [1:0] xe, xfd, xcf;
    logic [1:0] xd[2];
    logic [1:0] last_acc, pre_fd;

    function automatic int ww(int k);
        return (k == 0) ? 8 : 1;
    endfunction
    function automatic int wl(int k);
        return (k == 0) ? 2 : 1;
    endfunction
    function automatic int dp(int k);
        return (k == 0) ? 4 : 130;
    endfunction

    function automatic bit mready(int k);
        return rst_n && q[k].size() == 0 && !xcf[k];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            q[k].delete();
            xe[k] = 1'b0; xfd[k] = 1'b0; xcf[k] = 1'b0; xd[k] = '0;
        end
    endtask

    task automatic step();
        logic [1:0] acc;
        sym_t       s;
        logic [1:0] od;
        for (int k = 0; k < 2; k++) begin
            acc[k] = vld[k] && mready(k);
            pre_fd[k] = fd[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            xfd[k] = xcf[k];
            if (acc[k]) begin
                for (int i = 0; i < ww(k); i++) begin
                    s = '0;
                    for (int w = 0; w < wl(k); w++)
                        s.d[w] = dat[k][w*ww(k) + i];
                    q[k].push_back(s);
                end
                if (lst[k])
                    for (int j = 0; j < dp(k); j++) begin
                        s = '0;
                        s.fin = (j == dp(k) - 1);
                        q[k].push_back(s);
                    end
            end
            if (q[k].size() > 0) begin
                s = q[k].pop_front();
                xe[k] = 1'b1; xd[k] = s.d; xcf[k] = s.fin;
            end else begin
                xe[k] = 1'b0; xd[k] = '0; xcf[k] = 1'b0;
            end
        end
        last_acc = acc;
        #1;
        for (int k = 0; k < 2; k++) begin
            od = (k == 0) ? d0 : {1'b0, d1};
            chk($sformatf("sh_e[%0d]", k), e[k], xe[k]);
            chk($sformatf("sh_d[%0d]", k), od, xd[k]);
            chk($sformatf("busy[%0d]", k), bsy[k], xe[k]);
            chk($sformatf("flush_done[%0d]", k), fd[k], xfd[k]);
            chk($sformatf("s_ready[%0d]", k), rdy[k], mready(k));
        end
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic send(int k, logic [15:0] w, logic l);
        dat[k] = w; lst[k] = l; vld[k] = 1'b1;
        for (int n = 0; n < 400; n++) begin
            step();
            if (last_acc[k]) break;
        end
        chk($sformatf("accepted[%0d]", k), last_acc[k], 1'b1);
        vld[k] = 1'b0; lst[k] = 1'b0;
    endtask

    task automatic reset_checks();
        chk("rst_ready", rdy, 2'b00);
        chk("rst_sh_e", e, 2'b00);
        chk("rst_sh_d", {d1, d0}, 3'b000);
        chk("rst_busy", bsy, 2'b00);
        chk("rst_flush_done", fd, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0; vld = '0; lst = '0;
        dat[0] = '0; dat[1] = '0;
        last_acc = '0; pre_fd = '0;
        model_clear();
        #3 reset_checks();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_rst", rdy, 2'b11);

        send(0, 16'h00A5, 1'b1);
        idle(14);
        send(0, 16'h000F, 1'b0);
        send(0, 16'h00F0, 1'b1);
        idle(20);
        send(0, 16'h0033, 1'b0);
        idle(10);
        send(0, 16'h00CC, 1'b1);
        idle(14);
        send(0, 16'h3CA5, 1'b1);
        idle(14);

        for (int f = 0; f < 30; f++) begin
            int nw;
            nw = $urandom_range(1, 4);
            for (int i = 0; i < nw; i++) begin
                if ($urandom_range(0, 2) == 0)
                    idle($urandom_range(1, 4));
                send(0, 16'($urandom), i == nw - 1);
            end
        end
        idle(16);

        send(1, 16'h0001, 1'b1);
        send(1, 16'h0000, 1'b0);
        chk("accept_on_flush_done", pre_fd[1], 1'b1);
        for (int i = 0; i < 6; i++)
            send(1, 16'($urandom), i == 5);
        idle(140);

        send(1, 16'h0001, 1'b1);
        idle(51);
        #2 rst_n = 1'b0;
        #1 reset_checks();
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_midrst", rdy, 2'b11);
        idle(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
